hex_word_printer: RTL and testbench

//   Serialises a captured data word into ASCII hex characters, MS nibble first, for the debug UART path.

---
 rtl/hex_word_printer_if.sv | 25 ++
 rtl/hex_word_printer.sv | 110 +++++++++++
 tb/tb_hex_word_printer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_word_printer_if.sv
// Bus bundle for the hex word printer: upstream word handshake, hex2ascii
// side-channel and the UART character stream.
interface hex_word_printer_if #(
  parameter int NIBBLES = 8
);
  logic [4*NIBBLES-1:0] word_in;
  logic                 word_valid;
  logic                 word_ready;
  logic [3:0]           nib_out;
  logic [7:0]           ascii_in;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 busy;

  modport master (
    output word_in, word_valid, ascii_in, tx_ready,
    input  word_ready, nib_out, tx_data, tx_valid, busy
  );

  modport slave (
    input  word_in, word_valid, ascii_in, tx_ready,
    output word_ready, nib_out, tx_data, tx_valid, busy
  );
endinterface

// File: rtl/hex_word_printer.sv
// Prints a latched word as ASCII hex, MS nibble first, with optional CR/LF,
// using an external combinational hex2ascii converter for the digit glyphs.
module hex_word_printer #(
  parameter int NIBBLES     = 8,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  hex_word_printer_if.slave  io_bus
);
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEX  = 2'd1,
    S_CR   = 2'd2,
    S_LF   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [4*NIBBLES-1:0]  r_word;
  logic [IDX_W-1:0]      r_idx;
  logic                  w_accept;
  logic                  w_fire;
  logic                  w_idx_zero;
  logic [3:0]            w_nib [NIBBLES];
  logic [3:0]            w_nib_sel;
  logic                  w_tx_valid;
  logic [7:0]            w_tx_data;
  logic                  w_word_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign w_nib[gi] = r_word[4*gi +: 4];
    end
  endgenerate

  assign w_accept   = io_bus.word_valid && w_word_ready;
  assign w_fire     = w_tx_valid && io_bus.tx_ready;
  assign w_idx_zero = (r_idx == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = S_HEX;
      S_HEX: begin
        if (w_fire && w_idx_zero) begin
          w_state_next = APPEND_CRLF ? S_CR : S_IDLE;
        end
      end
      S_CR:   if (w_fire) w_state_next = S_LF;
      S_LF:   if (w_fire) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_tx_valid   = 1'b0;
    w_tx_data    = 8'h00;
    w_word_ready = 1'b0;
    case (r_state)
      S_IDLE: w_word_ready = 1'b1;
      S_HEX: begin
        w_tx_valid = 1'b1;
        w_tx_data  = io_bus.ascii_in;
      end
      S_CR: begin
        w_tx_valid = 1'b1;
        w_tx_data  = 8'h0D;
      end
      S_LF: begin
        w_tx_valid = 1'b1;
        w_tx_data  = 8'h0A;
      end
      default: w_word_ready = 1'b1;
    endcase
  end

  // The digit index only selects while in HEX; all other states show nibble 0.
  assign w_nib_sel = (r_state == S_HEX) ? w_nib[r_idx] : w_nib[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_idx  <= IDX_TOP;
    end else if (w_accept) begin
      r_word <= io_bus.word_in;
      r_idx  <= IDX_TOP;
    end else if (r_state == S_HEX && w_fire && !w_idx_zero) begin
      r_idx  <= r_idx - IDX_W'(1);
    end
  end

  assign io_bus.nib_out    = w_nib_sel;
  assign io_bus.tx_data    = w_tx_data;
  assign io_bus.tx_valid   = w_tx_valid;
  assign io_bus.word_ready = w_word_ready;
  assign io_bus.busy       = ~w_word_ready;
endmodule

// File: tb/tb_hex_word_printer.sv
// Directed bench for hex_word_printer: an expected-character queue per DUT is
// checked every cycle, plus literal string checks on what the UART received.
module tb_hex_word_printer;
  logic clk;
  logic rst_n;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  hex_word_printer_if #(.NIBBLES(8)) bus0 ();
  hex_word_printer_if #(.NIBBLES(2)) bus1 ();

  hex_word_printer #(.NIBBLES(8), .APPEND_CRLF(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .io_bus(bus0)
  );
  hex_word_printer #(.NIBBLES(2), .APPEND_CRLF(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .io_bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] hexch(input logic [3:0] d);
    return (d < 4'd10) ? (8'h30 + 8'(d)) : (8'h37 + 8'(d));
  endfunction

  // External hex2ascii converter.
  assign bus0.ascii_in = hexch(bus0.nib_out);
  assign bus1.ascii_in = hexch(bus1.nib_out);

  logic [11:0] exp_q [2][$];
  logic [7:0]  rx_q  [2][$];
  logic [3:0]  last_nib [2];

  task automatic chk(input int id, input string nm, input logic [15:0] act, input logic [15:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL dut%0d %s: got %h, expected %h at %0t", id, nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int id, input int nibbles, input bit crlf,
                            input logic wv, input logic [63:0] wi, input logic wr,
                            input logic bz, input logic tv, input logic tr,
                            input logic [7:0] td, input logic [3:0] nb);
    logic [11:0] head;
    logic [3:0]  d;
    if (!rst_n) begin
      exp_q[id].delete();
      last_nib[id] = 4'h0;
      chk(id, "rst_tx_valid", 16'(tv), 16'd0);
      chk(id, "rst_word_ready", 16'(wr), 16'd1);
      chk(id, "rst_tx_data", 16'(td), 16'd0);
      chk(id, "rst_nib_out", 16'(nb), 16'd0);
      return;
    end
    if (exp_q[id].size() == 0) begin
      chk(id, "idle_tx_valid", 16'(tv), 16'd0);
      chk(id, "idle_word_ready", 16'(wr), 16'd1);
      chk(id, "idle_busy", 16'(bz), 16'd0);
      chk(id, "idle_tx_data", 16'(td), 16'd0);
      chk(id, "idle_nib_out", 16'(nb), 16'(last_nib[id]));
      if (wv) begin
        for (int i = nibbles - 1; i >= 0; i--) begin
          d = 4'((wi >> (4 * i)) & 64'hF);
          exp_q[id].push_back({d, hexch(d)});
        end
        if (crlf) begin
          exp_q[id].push_back({wi[3:0], 8'h0D});
          exp_q[id].push_back({wi[3:0], 8'h0A});
        end
        last_nib[id] = wi[3:0];
      end
    end else begin
      head = exp_q[id][0];
      chk(id, "tx_valid", 16'(tv), 16'd1);
      chk(id, "word_ready", 16'(wr), 16'd0);
      chk(id, "busy", 16'(bz), 16'd1);
      chk(id, "tx_data", 16'(td), 16'(head[7:0]));
      chk(id, "nib_out", 16'(nb), 16'(head[11:8]));
      if (tr) begin
        void'(exp_q[id].pop_front());
        rx_q[id].push_back(td);
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0, 8, 1'b1, bus0.word_valid, {32'd0, bus0.word_in}, bus0.word_ready,
               bus0.busy, bus0.tx_valid, bus0.tx_ready, bus0.tx_data, bus0.nib_out);
    model_step(1, 2, 1'b0, bus1.word_valid, {56'd0, bus1.word_in}, bus1.word_ready,
               bus1.busy, bus1.tx_valid, bus1.tx_ready, bus1.tx_data, bus1.nib_out);
  end

  task automatic check_rx(input int id, input string nm, input string s, input bit crlf);
    int n;
    logic [7:0] e;
    logic [7:0] a;
    n = s.len() + (crlf ? 2 : 0);
    chk(id, {nm, "_len"}, 16'(rx_q[id].size()), 16'(n));
    for (int i = 0; i < n; i++) begin
      if (i < s.len()) e = s[i];
      else e = (i == s.len()) ? 8'h0D : 8'h0A;
      a = (i < rx_q[id].size()) ? rx_q[id][i] : 8'hFF;
      chk(id, nm, 16'(a), 16'(e));
    end
    $display("dut%0d %s: %0d characters received", id, nm, rx_q[id].size());
  endtask

  task automatic wait_idle(input int id, input string nm);
    int n = 0;
    logic b;
    b = id ? bus1.busy : bus0.busy;
    while (b && n < 300) begin
      @(posedge clk); #1;
      b = id ? bus1.busy : bus0.busy;
      n++;
    end
    chk(id, {nm, "_idle_timeout"}, 16'(b), 16'd0);
  endtask

  task automatic send0(input logic [31:0] w, input bit keep_valid);
    int   n = 0;
    logic acc = 1'b0;
    bus0.word_in    = w;
    bus0.word_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk); acc = bus0.word_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!keep_valid) bus0.word_valid = 1'b0;
    chk(0, "accept_timeout", 16'(acc), 16'd1);
  endtask

  task automatic send1(input logic [7:0] w);
    int   n = 0;
    logic acc = 1'b0;
    bus1.word_in    = w;
    bus1.word_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk); acc = bus1.word_ready;
      @(posedge clk); #1;
      n++;
    end
    bus1.word_valid = 1'b0;
    chk(1, "accept_timeout", 16'(acc), 16'd1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus0.word_in = '0; bus0.word_valid = 1'b0; bus0.tx_ready = 1'b0;
    bus1.word_in = '0; bus1.word_valid = 1'b0; bus1.tx_ready = 1'b0;
    #22 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk(0, "reset_word_ready", 16'(bus0.word_ready), 16'd1);
    chk(0, "reset_busy", 16'(bus0.busy), 16'd0);
    chk(0, "reset_tx_valid", 16'(bus0.tx_valid), 16'd0);
    chk(0, "reset_nib_out", 16'(bus0.nib_out), 16'd0);
    chk(1, "reset_word_ready", 16'(bus1.word_ready), 16'd1);

    // 1: back-to-back characters
    rx_q[0].delete();
    bus0.tx_ready = 1'b1;
    send0(32'hDEADBEEF, 1'b0);
    wait_idle(0, "t1");
    check_rx(0, "t1_deadbeef", "DEADBEEF", 1'b1);

    // 2: tx_ready toggling every cycle
    rx_q[0].delete();
    bus0.tx_ready = 1'b0;
    send0(32'h0123A9F0, 1'b0);
    n = 0;
    while (bus0.busy && n < 100) begin
      bus0.tx_ready = ~bus0.tx_ready;
      @(posedge clk); #1;
      n++;
    end
    chk(0, "t2_idle_timeout", 16'(bus0.busy), 16'd0);
    check_rx(0, "t2_0123a9f0", "0123A9F0", 1'b1);

    // 3: word_valid held with word_in changing during the transfer
    rx_q[0].delete();
    bus0.tx_ready = 1'b1;
    send0(32'hCAFE0042, 1'b1);
    n = 0;
    while (!bus0.word_ready && n < 100) begin
      bus0.word_in = $urandom;
      @(posedge clk); #1;
      n++;
    end
    bus0.word_valid = 1'b0;
    chk(0, "t3_idle_timeout", 16'(bus0.word_ready), 16'd1);
    check_rx(0, "t3_cafe0042", "CAFE0042", 1'b1);

    // 4: two nibbles, no CR/LF
    rx_q[1].delete();
    bus1.tx_ready = 1'b1;
    send1(8'h7C);
    wait_idle(1, "t4");
    check_rx(1, "t4_7c", "7C", 1'b0);

    // 5: reset pulse after three characters, then a full word
    rx_q[0].delete();
    bus0.tx_ready = 1'b1;
    send0(32'h12345678, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk(0, "t5_async_tx_valid", 16'(bus0.tx_valid), 16'd0);
    chk(0, "t5_async_word_ready", 16'(bus0.word_ready), 16'd1);
    check_rx(0, "t5_partial", "123", 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk(0, "t5_post_word_ready", 16'(bus0.word_ready), 16'd1);
    rx_q[0].delete();
    send0(32'h9ABCDEF0, 1'b0);
    wait_idle(0, "t5");
    check_rx(0, "t5_9abcdef0", "9ABCDEF0", 1'b1);

    // 6: long stall on the first character
    rx_q[0].delete();
    bus0.tx_ready = 1'b0;
    send0(32'h1BADF00D, 1'b0);
    repeat (20) begin
      @(negedge clk);
      chk(0, "t6_stall_valid", 16'(bus0.tx_valid), 16'd1);
      chk(0, "t6_stall_data", 16'(bus0.tx_data), 16'h31);
    end
    @(posedge clk); #1;
    bus0.tx_ready = 1'b1;
    wait_idle(0, "t6");
    check_rx(0, "t6_1badf00d", "1BADF00D", 1'b1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
